multi_user_input: RTL and testbench

MULTI_USER_INPUT -- requirements
Module: multi_user_input

---
 rtl/input_pkg.sv | 26 ++
 rtl/input_channel.sv | 151 +++++++++++++++
 rtl/multi_user_input.sv | 44 ++++
 tb/tb_multi_user_input.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/input_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// input_pkg : shared repeat-FSM encoding, default parameters and helpers
// rev 1.0
// ------------------------------------------------------------------------
package input_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2,
    ST_HELD   = 2'd3
  } rpt_state_t;

  localparam int DEF_N               = 4;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_REPEAT_DELAY    = 10;
  localparam int DEF_REPEAT_PERIOD   = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/input_channel.sv
`default_nettype none
// ------------------------------------------------------------------------
// input_channel : one button - synchronizer, debouncer, edge pulses and
// auto-repeat FSM; every output is a flop.                        rev 1.0
// ------------------------------------------------------------------------
module input_channel
  import input_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  input  logic repeat_en,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic rpt
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RC_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);

  localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RC_W-1:0] DELAY_LAST  = RC_W'(REPEAT_DELAY - 1);
  localparam logic [RC_W-1:0] PERIOD_LAST = RC_W'(REPEAT_PERIOD - 1);

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   sync;

  logic [DB_W-1:0] db_cnt;
  logic [DB_W-1:0] db_cnt_next;
  logic            level_next;
  logic            rise;
  logic            fall;

  rpt_state_t      state;
  rpt_state_t      state_next;
  logic [RC_W-1:0] rcnt;
  logic [RC_W-1:0] rcnt_next;
  logic            rpt_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], in};
    end
  end

  assign sync = sync_ff[SYNC_STAGES-1];

  // The level flips on the DEBOUNCE_CYCLES-th straight disagreement; any
  // agreeing sample restarts the run from zero.
  always_comb begin
    db_cnt_next = '0;
    level_next  = level;
    if (sync != level) begin
      if (db_cnt == DB_LAST) begin
        level_next = ~level;
      end else begin
        db_cnt_next = db_cnt + DB_W'(1);
      end
    end
  end

  assign rise = level_next & ~level;
  assign fall = level & ~level_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level         <= 1'b0;
      db_cnt        <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      level         <= level_next;
      db_cnt        <= db_cnt_next;
      press         <= rise;
      release_pulse <= fall;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      rcnt  <= '0;
      rpt   <= 1'b0;
    end else begin
      state <= state_next;
      rcnt  <= rcnt_next;
      rpt   <= rpt_next;
    end
  end

  // The level only rises while idle, so press and rpt never coincide; a
  // falling level overrides everything, keeping rpt off the release cycle.
  always_comb begin
    state_next = state;
    rcnt_next  = rcnt;
    rpt_next   = 1'b0;
    if (fall) begin
      state_next = ST_IDLE;
      rcnt_next  = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rise) begin
            state_next = repeat_en ? ST_DELAY : ST_HELD;
            rcnt_next  = '0;
          end
        end
        ST_DELAY: begin
          if (!repeat_en) begin
            state_next = ST_HELD;
            rcnt_next  = '0;
          end else if (rcnt == DELAY_LAST) begin
            rpt_next   = 1'b1;
            state_next = ST_REPEAT;
            rcnt_next  = '0;
          end else begin
            rcnt_next = rcnt + RC_W'(1);
          end
        end
        ST_REPEAT: begin
          if (!repeat_en) begin
            state_next = ST_HELD;
            rcnt_next  = '0;
          end else if (rcnt == PERIOD_LAST) begin
            rpt_next  = 1'b1;
            rcnt_next = '0;
          end else begin
            rcnt_next = rcnt + RC_W'(1);
          end
        end
        ST_HELD: begin
          rcnt_next = '0;
        end
        default: begin
          state_next = ST_IDLE;
          rcnt_next  = '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/multi_user_input.sv
`default_nettype none
// ------------------------------------------------------------------------
// multi_user_input : N independent debounced buttons with press/release
// pulses and auto-repeat.                                         rev 1.0
// ------------------------------------------------------------------------
module multi_user_input
  import input_pkg::*;
#(
  parameter int N               = DEF_N,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] in,
  input  logic         repeat_en,
  output logic [N-1:0] level,
  output logic [N-1:0] press,
  output logic [N-1:0] release_pulse,
  output logic [N-1:0] rpt
);

  for (genvar i = 0; i < N; i++) begin : g_ch
    input_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .in           (in[i]),
      .repeat_en    (repeat_en),
      .level        (level[i]),
      .press        (press[i]),
      .release_pulse(release_pulse[i]),
      .rpt          (rpt[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_user_input.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_multi_user_input : directed + randomized check of multi_user_input
// against a cycle-level behavioural model.                        rev 1.0
// ------------------------------------------------------------------------
module tb_multi_user_input;

  localparam int NCH  = 4;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int RD   = 10;
  localparam int RP   = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NCH-1:0]   in_bus;
  logic             repeat_en;
  logic [NCH-1:0]   level_bus;
  logic [NCH-1:0]   press_bus;
  logic [NCH-1:0]   rel_bus;
  logic [NCH-1:0]   rpt_bus;

  multi_user_input #(
    .N(NCH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in(in_bus), .repeat_en(repeat_en),
    .level(level_bus), .press(press_bus), .release_pulse(rel_bus), .rpt(rpt_bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // model: in samples still travelling through the synchronizer, plus
  // per-channel debounce run length, press time and repeat eligibility
  bit             hq [NCH][$];
  bit             m_lvl [NCH];
  int             m_run [NCH];
  int             m_tp  [NCH];
  bit             m_ok  [NCH];
  logic [NCH-1:0] e_level, e_press, e_rel, e_rpt;

  int press_cnt [NCH];
  int rel_cnt   [NCH];
  int rpt_cnt   [NCH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < NCH; ch++) begin
      hq[ch].delete();
      for (int s = 0; s < SYNC; s++) hq[ch].push_back(1'b0);
      m_lvl[ch] = 1'b0;
      m_run[ch] = 0;
      m_tp[ch]  = 0;
      m_ok[ch]  = 1'b0;
    end
    e_level = '0; e_press = '0; e_rel = '0; e_rpt = '0;
  endtask

  task automatic clr_counts();
    for (int ch = 0; ch < NCH; ch++) begin
      press_cnt[ch] = 0; rel_cnt[ch] = 0; rpt_cnt[ch] = 0;
    end
  endtask

  task automatic check_outputs();
    chk("level", 32'(level_bus), 32'(e_level));
    chk("press", 32'(press_bus), 32'(e_press));
    chk("release", 32'(rel_bus), 32'(e_rel));
    chk("rpt", 32'(rpt_bus), 32'(e_rpt));
  endtask

  task automatic tick();
    logic [NCH-1:0] pin;
    logic           pen;
    logic           prst;
    pin  = in_bus;
    pen  = repeat_en;
    prst = rst_n;
    @(posedge clk);
    #1;
    cyc++;
    if (!prst) begin
      model_reset();
    end else begin
      for (int ch = 0; ch < NCH; ch++) begin
        bit cmp;
        bit old;
        int k;
        cmp = hq[ch].pop_front();
        hq[ch].push_back(pin[ch]);
        old = m_lvl[ch];
        if (cmp != m_lvl[ch]) begin
          m_run[ch]++;
          if (m_run[ch] == DEB) begin
            m_lvl[ch] = ~m_lvl[ch];
            m_run[ch] = 0;
          end
        end else begin
          m_run[ch] = 0;
        end
        e_level[ch] = m_lvl[ch];
        e_press[ch] = !old && m_lvl[ch];
        e_rel[ch]   = old && !m_lvl[ch];
        e_rpt[ch]   = 1'b0;
        if (e_press[ch]) begin
          m_tp[ch] = cyc;
          m_ok[ch] = pen;
        end else if (old && m_lvl[ch]) begin
          m_ok[ch] = m_ok[ch] && pen;
          k = cyc - m_tp[ch];
          e_rpt[ch] = m_ok[ch] && (k >= RD) && (((k - RD) % RP) == 0);
        end
      end
    end
    for (int ch = 0; ch < NCH; ch++) begin
      press_cnt[ch] += int'(press_bus[ch]);
      rel_cnt[ch]   += int'(rel_bus[ch]);
      rpt_cnt[ch]   += int'(rpt_bus[ch]);
    end
    check_outputs();
  endtask

  task automatic async_reset_check();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
  endtask

  initial begin
    int lat;
    int t;
    int thr [NCH];

    rst_n = 1'b0; in_bus = '0; repeat_en = 1'b0;
    model_reset();
    clr_counts();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (4) tick();

    // single press, no repeat: rise and fall latency, one press, no rpt
    clr_counts();
    in_bus[0] = 1'b1;
    lat = -1;
    for (int j = 1; j <= 20; j++) begin
      tick();
      if (lat < 0 && level_bus[0]) lat = j;
    end
    chk("rise_latency", 32'(lat), 32'(SYNC + DEB));
    in_bus[0] = 1'b0;
    lat = -1;
    for (int j = 1; j <= 12; j++) begin
      tick();
      if (lat < 0 && rel_bus[0]) lat = j;
    end
    chk("fall_latency", 32'(lat), 32'(SYNC + DEB));
    chk("press_count_ch0", 32'(press_cnt[0]), 32'd1);
    chk("rpt_count_ch0", 32'(rpt_cnt[0]), 32'd0);

    // short glitch is filtered completely
    clr_counts();
    in_bus[1] = 1'b1;
    repeat (3) tick();
    in_bus[1] = 1'b0;
    repeat (10) tick();
    chk("glitch_pulses_ch1", 32'(press_cnt[1] + rel_cnt[1] + rpt_cnt[1]), 32'd0);

    // long hold with repeat enabled: pulses at t+10, t+13, ... t+28
    clr_counts();
    repeat_en = 1'b1;
    in_bus[2] = 1'b1;
    repeat (30) tick();
    in_bus[2] = 1'b0;
    repeat (10) tick();
    chk("rpt_count_full_hold", 32'(rpt_cnt[2]), 32'd7);

    // repeat_en dropped at t+14 and raised at t+20: only t+10, t+13 fire
    clr_counts();
    in_bus[2] = 1'b1;
    t = -1;
    for (int j = 1; j <= 30; j++) begin
      tick();
      if (t < 0 && press_bus[2]) t = j;
      if (t >= 0 && j == t + 14) repeat_en = 1'b0;
      if (t >= 0 && j == t + 20) repeat_en = 1'b1;
    end
    in_bus[2] = 1'b0;
    repeat (10) tick();
    chk("rpt_count_dropped_en", 32'(rpt_cnt[2]), 32'd2);
    chk("press_time_ch2", 32'(t), 32'(SYNC + DEB));

    // simultaneous presses, then reset mid-hold and re-press afterwards
    clr_counts();
    in_bus[0] = 1'b1; in_bus[3] = 1'b1;
    repeat (8) tick();
    chk("press_count_ch0_ch3", 32'(press_cnt[0] + press_cnt[3]), 32'd2);
    clr_counts();
    async_reset_check();
    repeat (2) tick();
    rst_n = 1'b1;
    lat = -1;
    for (int j = 1; j <= 12; j++) begin
      tick();
      if (lat < 0 && press_bus[0]) lat = j;
    end
    chk("press_after_reset", 32'(lat), 32'(SYNC + DEB));
    chk("no_release_on_reset", 32'(rel_cnt[0] + rel_cnt[3]), 32'd0);
    in_bus = '0;
    repeat (12) tick();

    // randomized traffic with varying toggle rates and occasional resets
    for (int ch = 0; ch < NCH; ch++) thr[ch] = 8;
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0)
        for (int ch = 0; ch < NCH; ch++) thr[ch] = int'($urandom_range(1, 40));
      for (int ch = 0; ch < NCH; ch++)
        if ($urandom_range(0, thr[ch]) == 0) in_bus[ch] = ~in_bus[ch];
      if ($urandom_range(0, 40) == 0) repeat_en = ~repeat_en;
      if ($urandom_range(0, 600) == 0) begin
        async_reset_check();
        tick();
        rst_n = 1'b1;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
